// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - reassembles an LSB-first serial bitstream into a parallel word
//
// Purpose: collects WIDTH serial bits following a start pulse (after LATENCY
// alignment edges) and presents the word through a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   areset     asynchronous active-high reset
//   start      single-cycle frame start pulse
//   bit_in     serial data, LSB first
//   out_ready  consumer accepts word_out this cycle
//   clear_err  synchronous clear of overrun
//   word_out   assembled word, stable while word_valid=1
//   word_valid word_out holds a complete, unconsumed word
//   busy       high while aligning or shifting
//   overrun    sticky: a start pulse was dropped
module serial_word_collector #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             busy,
  output logic             overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [2:0]    ALIGN_LOAD = 3'(LATENCY >= 1 ? LATENCY - 1 : 0);
  // LATENCY=1 needs no idle alignment edge: the very next edge samples bit 0.
  localparam logic [1:0]    ENTRY      = (LATENCY >= 2) ? ALIGN : SHIFT;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [2:0]       align_cnt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             take_start;
  logic             drop_start;

  assign take_start = start && ((state == IDLE) || (state == HOLD && out_ready));
  assign drop_start = start && ((state == ALIGN) || (state == SHIFT) ||
                                (state == HOLD && !out_ready));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ENTRY;
      ALIGN:   if (align_cnt == 3'd1) state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = HOLD;
      HOLD:    if (out_ready) state_next = start ? ENTRY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      align_cnt  <= 3'd0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ALIGN) || (state_next == SHIFT);

      // Set wins over a simultaneous clear.
      if (drop_start) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      case (state)
        ALIGN: align_cnt <= align_cnt - 3'd1;
        SHIFT: begin
          // Right-shifting in at the MSB leaves bit 0 at the LSB after WIDTH bits.
          shreg <= {bit_in, shreg[WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            word_out   <= {bit_in, shreg[WIDTH-1:1]};
            word_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        HOLD:    if (out_ready) word_valid <= 1'b0;
        default: ;
      endcase

      // Frame entry is identical from IDLE and from a consuming HOLD edge.
      if (take_start) begin
        align_cnt <= ALIGN_LOAD;
        if (LATENCY == 0) begin
          shreg   <= {bit_in, shreg[WIDTH-1:1]};
          bit_cnt <= CW'(1);
        end else begin
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule
